// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and defaults for the pwm engine and its plane controller
package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 16;
  localparam int NUM_PWM_DEF   = 4;

  localparam int PWM_ADDR_W = (PWM_WIDTH_DEF > 1) ? $clog2(PWM_WIDTH_DEF) : 1;
  localparam int PWM_CH_W   = (NUM_PWM_DEF > 1) ? $clog2(NUM_PWM_DEF) : 1;

  typedef logic [PWM_ADDR_W-1:0] pwm_addr_t;
  typedef logic [PWM_CH_W-1:0]   pwm_ch_t;

  typedef enum logic {
    PLANE_IDLE,
    PLANE_PENDING
  } plane_state_t;

endpackage

// File: rtl/pwm_plane_bank.sv
// rtl/pwm_plane_bank.sv - bit-plane register array with transposed column write, bulk load and plane read
module pwm_plane_bank #(
  parameter int W   = 16,
  parameter int N   = 4,
  parameter int CHW = (N > 1) ? $clog2(N) : 1,
  parameter int AW  = (W > 1) ? $clog2(W) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_col,
  input  logic [W-1:0]   wr_bits,
  input  logic           load_en,
  input  logic [W*N-1:0] load_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [N-1:0]   rd_data,
  output logic [W*N-1:0] mem_all
);

  // Bit (plane i, channel c) lives at i*N + c, so a plane is one contiguous N-bit slice.
  logic [W*N-1:0] mem_q;
  logic [W*N-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d = load_data;
    end else if (wr_en && (int'(wr_col) < N)) begin
      for (int i = 0; i < W; i++) begin
        mem_d[i*N + int'(wr_col)] = wr_bits[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < W) begin
      rd_data = mem_q[int'(rd_addr)*N +: N];
    end
  end

  assign mem_all = mem_q;

endmodule

// File: rtl/pwm_plane_ctrl.sv
// rtl/pwm_plane_ctrl.sv - double-buffered bit-plane controller for the pwm engine
// Optional duty readback port enabled by PWM_PLANE_CTRL_READBACK_EN.
module pwm_plane_ctrl
  import pwm_pkg::*;
#(
  parameter int pwm_width = PWM_WIDTH_DEF,
  parameter int num_pwm   = NUM_PWM_DEF,
  parameter int CHW       = (num_pwm > 1) ? $clog2(num_pwm) : 1,
  parameter int AW        = (pwm_width > 1) ? $clog2(pwm_width) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [pwm_width-1:0] wr_duty,
  input  logic                 commit,
  output logic                 commit_busy,
  output logic                 commit_done,
  input  logic                 latch_mem,
  input  logic [AW-1:0]        pwm_addr,
`ifdef PWM_PLANE_CTRL_READBACK_EN
  input  logic [CHW-1:0]       rd_ch,
  output logic [pwm_width-1:0] rd_duty,
`endif
  output logic [num_pwm-1:0]   pwm_data
);

  plane_state_t state_q, state_d;
  logic         commit_done_q, commit_done_d;
  logic         copy_en;
  logic         wr_fire;

  logic [pwm_width*num_pwm-1:0] shadow_all;
  logic [pwm_width*num_pwm-1:0] active_all;
  logic [num_pwm-1:0]           unused_shadow_plane;

  // A commit seen together with latch_mem only arms; the copy waits for the next frame boundary.
  always_comb begin
    state_d       = state_q;
    wr_ready      = 1'b0;
    commit_busy   = 1'b0;
    copy_en       = 1'b0;
    commit_done_d = 1'b0;
    case (state_q)
      PLANE_IDLE: begin
        wr_ready = 1'b1;
        if (commit) begin
          state_d = PLANE_PENDING;
        end
      end
      PLANE_PENDING: begin
        commit_busy = 1'b1;
        if (latch_mem) begin
          copy_en       = 1'b1;
          commit_done_d = 1'b1;
          state_d       = PLANE_IDLE;
        end
      end
      default: state_d = PLANE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= PLANE_IDLE;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign commit_done = commit_done_q;
  assign wr_fire     = wr_valid & wr_ready;

  pwm_plane_bank #(
    .W(pwm_width),
    .N(num_pwm),
    .CHW(CHW),
    .AW(AW)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_fire),
    .wr_col   (wr_ch),
    .wr_bits  (wr_duty),
    .load_en  (1'b0),
    .load_data('0),
    .rd_addr  (pwm_addr),
    .rd_data  (unused_shadow_plane),
    .mem_all  (shadow_all)
  );

  pwm_plane_bank #(
    .W(pwm_width),
    .N(num_pwm),
    .CHW(CHW),
    .AW(AW)
  ) u_active (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (1'b0),
    .wr_col   ('0),
    .wr_bits  ('0),
    .load_en  (copy_en),
    .load_data(shadow_all),
    .rd_addr  (pwm_addr),
    .rd_data  (pwm_data),
    .mem_all  (active_all)
  );

`ifdef PWM_PLANE_CTRL_READBACK_EN
  logic [pwm_width-1:0] rd_duty_q, rd_duty_d;

  always_comb begin
    rd_duty_d = '0;
    if (int'(rd_ch) < num_pwm) begin
      for (int i = 0; i < pwm_width; i++) begin
        rd_duty_d[i] = active_all[i*num_pwm + int'(rd_ch)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_duty_q <= '0;
    end else begin
      rd_duty_q <= rd_duty_d;
    end
  end

  assign rd_duty = rd_duty_q;
`else
  logic unused_active;
  assign unused_active = ^active_all;
`endif

endmodule
